// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and types for the instruction fetch queue.
// The defines form the shared header; the package mirrors them as typed constants.
`ifndef INST_FETCH_QUEUE_DEFINES
`define INST_FETCH_QUEUE_DEFINES
`define INST_W      16
`define INST_ADDR_W 5
`define FETCH_DEPTH 4
`endif

package inst_fetch_queue_pkg;
  localparam int INST_W      = `INST_W;
  localparam int INST_ADDR_W = `INST_ADDR_W;

  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  // One queue entry: the fetched instruction and the index it came from.
  typedef struct packed {
    inst_t      data;
    inst_addr_t pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: program-memory port, redirect input and the core-facing
// instruction handshake. master = surrounding core/memory, slave = fetch queue.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic       en;
  inst_addr_t progmem_addr;
  inst_t      progmem_data;
  logic       redirect_valid;
  inst_addr_t redirect_pc;
  logic       inst_valid;
  inst_t      inst_data;
  inst_addr_t inst_pc;
  logic       inst_ready;

  modport master (
    output en, progmem_data, redirect_valid, redirect_pc, inst_ready,
    input  progmem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    input  en, progmem_data, redirect_valid, redirect_pc, inst_ready,
    output progmem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} entries.
// Flush empties it in one edge and overrides any same-cycle push or pop.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = ENTRY_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; r_count alone decides
    // which entries are meaningful, so stale data is never observed as valid.
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues program-memory reads, captures the
// registered read data one cycle later into a small queue, and presents the
// queue head to the core. Redirect flushes everything and restarts fetch.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = `FETCH_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  inst_addr_t r_fetch_pc;
  inst_addr_t r_req_pc;
  logic       r_pending;

  logic [CNT_W-1:0] w_count;
  logic [OCC_W-1:0] w_occupancy;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;
  logic [ENTRY_W-1:0] w_head_bits;

  // Occupancy counts the in-flight response so a slot is reserved for it;
  // this is what keeps the queue from ever overflowing.
  assign w_occupancy = {1'b0, w_count} + OCC_W'(r_pending);
  assign w_issue     = bus.en && !bus.redirect_valid && (w_occupancy < OCC_W'(DEPTH));

  // The response is captured regardless of en; a redirect discards it.
  assign w_push = r_pending && !bus.redirect_valid;
  assign w_pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

  assign w_push_entry = '{data: bus.progmem_data, pc: r_req_pc};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_count (w_count)
  );

  // Fetch pointer and in-flight request tracking; redirect outranks issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= '0;
      r_req_pc   <= '0;
      r_pending  <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + INST_ADDR_W'(1);
      end
    end
  end

  assign w_head = fetch_entry_t'(w_head_bits);

  assign bus.progmem_addr = r_fetch_pc;
  assign bus.inst_valid   = (w_count != '0);
  assign bus.inst_data    = w_head.data;
  assign bus.inst_pc      = w_head.pc;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AMOD  = 1 << INST_ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  inst_fetch_queue_if bus ();

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Program memory with a one-cycle registered read.
  inst_t mem [AMOD];
  always @(posedge clk) bus.progmem_data <= mem[bus.progmem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fetch pointer, one optional in-flight pc, queue of pcs.
  int m_q[$];
  bit m_pending  = 0;
  int m_req_pc   = 0;
  int m_fetch_pc = 0;

  typedef struct {
    logic rst_n;
    logic en;
    logic rv;
    int   rpc;
    logic rdy;
    logic exp_valid;
    int   exp_pc;
    int   exp_addr;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  cnt   = m_q.size();
    bit  pend  = m_pending;
    int  rpc   = m_req_pc;
    bit  issue;
    if (!rst_n) begin
      m_q.delete();
      m_pending  = 0;
      m_fetch_pc = 0;
    end else if (bus.redirect_valid) begin
      m_q.delete();
      m_pending  = 0;
      m_fetch_pc = int'(bus.redirect_pc);
    end else begin
      issue = bus.en && (cnt + int'(pend) < DEPTH);
      if (cnt > 0 && bus.inst_ready) void'(m_q.pop_front());
      if (pend) m_q.push_back(rpc);
      m_pending = issue;
      if (issue) begin
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = (m_fetch_pc + 1) % AMOD;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rv, input int rpc, input logic rdy);
    rst_n              = r;
    bus.en             = e;
    bus.redirect_valid = rv;
    bus.redirect_pc    = inst_addr_t'(rpc);
    bus.inst_ready     = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic compare_model();
    check("model_valid", bus.inst_valid, (m_q.size() != 0));
    check("model_addr", bus.progmem_addr, m_fetch_pc);
    if (m_q.size() != 0) begin
      check("model_pc", bus.inst_pc, m_q[0]);
      check("model_data", bus.inst_data, mem[m_q[0]]);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < AMOD; i++) mem[i] = inst_t'(i + 100);
    bus.en = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;

    //            rst en rv rpc rdy  v  pc addr
    vecs[0]  = '{1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b0,  0,  0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0,  0, 1'b1, 1'b0,  0,  0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b0,  0,  1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1,  0,  2};
    vecs[4]  = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1,  1,  3};
    vecs[5]  = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1,  2,  4};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 1'b0,  0, 20};
    vecs[7]  = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b0,  0, 21};
    vecs[8]  = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1, 20, 22};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 10, 1'b1, 1'b0,  0, 10};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 30, 1'b1, 1'b0,  0, 30};
    vecs[11] = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b0,  0, 31};
    vecs[12] = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1, 30,  0};
    vecs[13] = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1, 31,  1};
    vecs[14] = '{1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b1,  0,  2};
    vecs[15] = '{1'b0, 1'b1, 1'b0,  0, 1'b1, 1'b0,  0,  0};

    // Directed table: reset, startup latency, streaming, redirects, address wrap.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), bus.inst_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_addr", i), bus.progmem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), bus.inst_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_data", i), bus.inst_data, vecs[i].exp_pc + 100);
      end
    end

    // Backpressure: queue fills to DEPTH, fetch stalls at 4, drain is in order.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 0, 1'b0);
      compare_model();
    end
    check("stall_addr", bus.progmem_addr, 4);
    check("stall_head", bus.inst_pc, 0);
    for (int k = 0; k < 5; k++) begin
      check("drain_valid", bus.inst_valid, 1'b1);
      check("drain_pc", bus.inst_pc, k);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);
      compare_model();
    end

    // Redirect while queue holds 3..5 and 6 is in flight, with a same-cycle pop.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("pre_redir_head", bus.inst_pc, 3);
    check("pre_redir_addr", bus.progmem_addr, 7);
    step(1'b1, 1'b1, 1'b1, 20, 1'b1);
    check("redir_flush_valid", bus.inst_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("redir_gap_valid", bus.inst_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("redir_first_valid", bus.inst_valid, 1'b1);
    check("redir_first_pc", bus.inst_pc, 20);

    // en dropped with a request pending: response lands, fetch_pc frozen.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("en0_pushed", bus.inst_valid, 1'b1);
    check("en0_addr", bus.progmem_addr, 1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("en0_frozen", bus.progmem_addr, 1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("en1_resume", bus.progmem_addr, 2);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("en1_next_pc", bus.inst_pc, 1);
    compare_model();

    // Redirect coinciding with push and pop at a fully reserved queue.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("full_addr", bus.progmem_addr, 4);
    step(1'b1, 1'b1, 1'b1, 9, 1'b1);
    check("full_redir_valid", bus.inst_valid, 1'b0);
    check("full_redir_addr", bus.progmem_addr, 9);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    check("full_redir_quiet", bus.inst_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("full_redir_gap", bus.inst_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    check("full_redir_pc", bus.inst_pc, 9);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 19) == 0),
           int'($urandom_range(0, AMOD - 1)),
           ($urandom_range(0, 9) < 7));
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of instruction-queue entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 en  input  1  fetch enable; when low, no new program-memory request SHALL be issued.
REQ-005 progmem_addr  output  `INST_ADDR_W  instruction-index address to program memory.
REQ-006 progmem_data  input  `INST_W  instruction returned one cycle after its address was presented (registered read).
REQ-007 redirect_valid  input  1  core request to flush and restart fetch.
REQ-008 redirect_pc  input  `INST_ADDR_W  restart instruction index.
REQ-009 inst_valid  output  1  queue head holds a valid instruction.
REQ-010 inst_data  output  `INST_W  head instruction.
REQ-011 inst_pc  output  `INST_ADDR_W  index of head instruction.
REQ-012 inst_ready  input  1  core consumes head when inst_valid && inst_ready.

Function
REQ-013 progmem_addr SHALL equal the fetch_pc register combinationally.
REQ-014 A request SHALL issue in a cycle iff en=1, redirect_valid=0 and (count + pending) < DEPTH; on issue fetch_pc <= fetch_pc+1 (modulo 2^`INST_ADDR_W, wrap to 0 without error) and pending <= 1 with req_pc <= fetch_pc; otherwise pending <= 0.
REQ-015 When pending=1 and no redirect, {progmem_data, req_pc} SHALL be pushed into the queue at the next edge, regardless of en.
REQ-016 Pop SHALL occur on inst_valid && inst_ready; push and pop in one cycle SHALL leave count unchanged.
REQ-017 inst_valid SHALL equal (count != 0); inst_data/inst_pc SHALL reflect the head entry and stay stable while inst_valid && !inst_ready.
REQ-018 Queue SHALL never overflow; issue gating (REQ-014) guarantees space for every in-flight response.
REQ-019 redirect_valid=1 SHALL have priority over all events: queue flushed (count <= 0), pending <= 0, in-flight response discarded, any same-cycle pop ignored, fetch_pc <= redirect_pc; applies even when en=0.
REQ-020 After redirect, first request SHALL issue the following cycle; the redirect_pc instruction SHALL appear with inst_valid=1 two edges after the redirect edge.
REQ-021 Back-to-back redirects SHALL each be honoured; the last one wins.
REQ-022 Steady state with inst_ready=1 and en=1 SHALL sustain one instruction per cycle.

Reset
REQ-023 While rst_n=0 at an edge: fetch_pc <= 0, pending <= 0, count <= 0, queue pointers <= 0; hence inst_valid=0, progmem_addr=0.
REQ-024 Reset asserted mid-operation SHALL discard queue contents and in-flight response; inst_data/inst_pc values are don't-care while inst_valid=0.
REQ-025 First edge with rst_n=1 issues address 0; inst_valid SHALL rise after the second such edge.

Structure
REQ-026 `INST_W, `INST_ADDR_W and new `FETCH_DEPTH default SHALL live in the shared defines header.
REQ-027 Queue SHALL be a sub-module fetch_fifo (sync FIFO, width `INST_W+`INST_ADDR_W, flush input, count output).

Verification
REQ-028 Reset then en=1, inst_ready=1, mem[i]=i+100 -> inst_valid rises 2 edges after reset release; inst_pc 0,1,2,... one per cycle, inst_data 100,101,...
REQ-029 inst_ready=0 for 10 cycles, DEPTH=4 -> count stops at 4, progmem_addr holds at 4, no entry lost; resuming delivers pc 0..4 in order.
REQ-030 Redirect to 20 while queue holds pc 3..5 and pc 6 in flight -> pc 3..6 never delivered; next delivered inst_pc=20, two edges after redirect.
REQ-031 en=0 with one request pending -> response still enqueued, fetch_pc frozen; en=1 resumes at next index.
REQ-032 fetch_pc at 2^`INST_ADDR_W-1 -> next delivered inst_pc=0.
REQ-033 Redirect coincident with pop and push at full queue -> queue empty next cycle, no spurious inst_valid.
